// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Desc     : Shared defaults, state encoding and helpers for matrix_sender.
//            State CKSUM exists only with MATRIX_SENDER_CHECKSUM_EN defined.
// Revision : 1.0
// ============================================================================
package matrix_pkg;

   localparam int DEFAULT_MAX_ELEMENT_SIZE = 8;
   localparam int DEFAULT_MAX_SIZE         = 32;
   localparam int DIBITS_PER_ELEMENT       = DEFAULT_MAX_ELEMENT_SIZE / 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRIME  = 3'd1,
      SEND   = 3'd2,
`ifdef MATRIX_SENDER_CHECKSUM_EN
      CKSUM  = 3'd3,
`endif
      FINISH = 3'd4
   } sender_state_t;

   // Keeps counters at least one bit wide when a limit collapses to 1.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/row_serializer.sv
`default_nettype none
// ============================================================================
// Module   : row_serializer
// Desc     : Row shift/shadow registers with dibit and element counters.
// Revision : 1.0
// ============================================================================
module row_serializer
   import matrix_pkg::*;
#(
   parameter int ELEM_W = DEFAULT_MAX_ELEMENT_SIZE,
   parameter int ELEMS  = DEFAULT_MAX_SIZE
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    load_i,
   input  logic                    shadow_i,
   input  logic                    adv_i,
   input  logic [ELEM_W*ELEMS-1:0] data_i,
   output logic [1:0]              dibit_o,
   output logic                    row_start_o,
   output logic                    row_end_o
);

   localparam int RW  = ELEM_W * ELEMS;
   localparam int DPE = ELEM_W / 2;
   localparam int DW  = clog2_min1(DPE);
   localparam int EW  = clog2_min1(ELEMS);

   logic [RW-1:0] shift_q, shift_d;
   logic [RW-1:0] shadow_q, shadow_d;
   logic [DW-1:0] dib_q, dib_d;
   logic [EW-1:0] elem_q, elem_d;
   logic          w_last_dibit;
   logic          w_last_elem;

   assign w_last_dibit = (dib_q == DW'(DPE - 1));
   assign w_last_elem  = (elem_q == EW'(ELEMS - 1));
   assign row_end_o    = w_last_dibit && w_last_elem;
   assign row_start_o  = (dib_q == '0) && (elem_q == '0);
   assign dibit_o      = shift_q[RW-1 -: 2];

   always_comb begin
      shift_d  = shift_q;
      shadow_d = shadow_q;
      dib_d    = dib_q;
      elem_d   = elem_q;
      if (shadow_i) begin
         shadow_d = data_i;
      end
      if (load_i) begin
         shift_d = data_i;
         dib_d   = '0;
         elem_d  = '0;
      end else if (adv_i) begin
         // Swapping in the shadow row on the last dibit keeps rows back to back.
         if (row_end_o) begin
            shift_d = shadow_q;
            dib_d   = '0;
            elem_d  = '0;
         end else begin
            shift_d = shift_q << 2;
            if (w_last_dibit) begin
               dib_d  = '0;
               elem_d = elem_q + 1'b1;
            end else begin
               dib_d  = dib_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shift_q  <= '0;
         shadow_q <= '0;
         dib_q    <= '0;
         elem_q   <= '0;
      end else begin
         shift_q  <= shift_d;
         shadow_q <= shadow_d;
         dib_q    <= dib_d;
         elem_q   <= elem_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/matrix_sender.sv
`default_nettype none
// ============================================================================
// Module   : matrix_sender
// Desc     : Streams a MAX_SIZE x MAX_SIZE matrix as dibits, row by row.
//            MATRIX_SENDER_CHECKSUM_EN appends an XOR checksum element.
// Revision : 1.0
// ============================================================================
module matrix_sender
   import matrix_pkg::*;
#(
   parameter int MAX_ELEMENT_SIZE = DEFAULT_MAX_ELEMENT_SIZE,
   parameter int MAX_SIZE         = DEFAULT_MAX_SIZE,
   parameter int READ_LATENCY     = 2
) (
   input  logic                               eth_refclk,
   input  logic                               rst,
   input  logic                               start,
   output logic                               row_rd_en,
   output logic [$clog2(MAX_SIZE)-1:0]        row_addr,
   input  logic [MAX_SIZE*MAX_ELEMENT_SIZE-1:0] row_data,
   output logic                               axiov,
   output logic [1:0]                         axiod,
   output logic                               busy,
   output logic                               done
);

   localparam int AW = $clog2(MAX_SIZE);

   sender_state_t state_q, state_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    rd_en_q, rd_en_d;
   logic [AW-1:0]           addr_q, addr_d;
   logic [AW-1:0]           row_q, row_d;
   logic [READ_LATENCY-1:0] vld_q;
   logic                    axiov_q, axiov_d;
   logic [1:0]              axiod_q, axiod_d;
   logic                    w_cap;
   logic                    w_ser_load, w_ser_shadow, w_ser_adv;
   logic [1:0]              w_ser_dibit;
   logic                    w_row_start, w_row_end;

   // Capture strobe trails each read pulse by exactly READ_LATENCY cycles.
   assign w_cap = vld_q[READ_LATENCY-1];

   row_serializer #(
      .ELEM_W (MAX_ELEMENT_SIZE),
      .ELEMS  (MAX_SIZE)
   ) u_ser (
      .clk_i       (eth_refclk),
      .rst_i       (rst),
      .load_i      (w_ser_load),
      .shadow_i    (w_ser_shadow),
      .adv_i       (w_ser_adv),
      .data_i      (row_data),
      .dibit_o     (w_ser_dibit),
      .row_start_o (w_row_start),
      .row_end_o   (w_row_end)
   );

`ifdef MATRIX_SENDER_CHECKSUM_EN
   localparam int DPE = MAX_ELEMENT_SIZE / 2;
   localparam int DW  = clog2_min1(DPE);

   logic [MAX_ELEMENT_SIZE-1:0] cks_q, cks_d;
   logic [DW-1:0]               ckcnt_q, ckcnt_d;
   logic [MAX_ELEMENT_SIZE-1:0] w_fold;
   logic [MAX_ELEMENT_SIZE-1:0] w_ck_shift;

   always_comb begin
      w_fold = '0;
      for (int i = 0; i < MAX_SIZE; i++) begin
         w_fold = w_fold ^ row_data[i*MAX_ELEMENT_SIZE +: MAX_ELEMENT_SIZE];
      end
   end

   assign w_ck_shift = cks_q << {ckcnt_q, 1'b0};
`endif

   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      rd_en_d      = 1'b0;
      addr_d       = addr_q;
      row_d        = row_q;
      axiov_d      = 1'b0;
      axiod_d      = 2'b00;
      w_ser_load   = 1'b0;
      w_ser_shadow = 1'b0;
      w_ser_adv    = 1'b0;
`ifdef MATRIX_SENDER_CHECKSUM_EN
      cks_d        = cks_q;
      ckcnt_d      = ckcnt_q;
      if (w_cap) begin
         cks_d = cks_q ^ w_fold;
      end
`endif
      case (state_q)
         IDLE: begin
            // done_q still high means start arrived alongside done; drop it.
            if (start && !done_q) begin
               state_d = PRIME;
               busy_d  = 1'b1;
               rd_en_d = 1'b1;
               addr_d  = '0;
               row_d   = '0;
`ifdef MATRIX_SENDER_CHECKSUM_EN
               cks_d   = '0;
               ckcnt_d = '0;
`endif
            end
         end
         PRIME: begin
            if (w_cap) begin
               w_ser_load = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            w_ser_adv    = 1'b1;
            w_ser_shadow = w_cap;
            axiov_d      = 1'b1;
            axiod_d      = w_ser_dibit;
            if (w_row_start && (row_q != AW'(MAX_SIZE - 1))) begin
               rd_en_d = 1'b1;
               addr_d  = row_q + 1'b1;
            end
            if (w_row_end) begin
               if (row_q == AW'(MAX_SIZE - 1)) begin
`ifdef MATRIX_SENDER_CHECKSUM_EN
                  state_d = CKSUM;
`else
                  state_d = FINISH;
`endif
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
`ifdef MATRIX_SENDER_CHECKSUM_EN
         CKSUM: begin
            axiov_d = 1'b1;
            axiod_d = w_ck_shift[MAX_ELEMENT_SIZE-1 -: 2];
            ckcnt_d = ckcnt_q + 1'b1;
            if (ckcnt_q == DW'(DPE - 1)) begin
               state_d = FINISH;
            end
         end
`endif
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge eth_refclk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;
         addr_q  <= '0;
         row_q   <= '0;
         vld_q   <= '0;
         axiov_q <= 1'b0;
         axiod_q <= 2'b00;
`ifdef MATRIX_SENDER_CHECKSUM_EN
         cks_q   <= '0;
         ckcnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rd_en_q  <= rd_en_d;
         addr_q   <= addr_d;
         row_q    <= row_d;
         vld_q[0] <= rd_en_q;
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
         end
         axiov_q  <= axiov_d;
         axiod_q  <= axiod_d;
`ifdef MATRIX_SENDER_CHECKSUM_EN
         cks_q    <= cks_d;
         ckcnt_q  <= ckcnt_d;
`endif
      end
   end

   assign row_rd_en = rd_en_q;
   assign row_addr  = addr_q;
   assign axiov     = axiov_q;
   assign axiod     = axiod_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_sender
// Desc     : Directed bench for matrix_sender with a two-cycle model row source.
// Revision : 1.0
// ============================================================================
module tb_matrix_sender;

   localparam int ES    = 8;
   localparam int MS    = 32;
   localparam int LAT   = 2;
   localparam int NDATA = MS * MS * ES / 2;
`ifdef MATRIX_SENDER_CHECKSUM_EN
   localparam int TOTAL = NDATA + ES / 2;
`else
   localparam int TOTAL = NDATA;
`endif

   typedef struct {
      string      name;
      int         idx;
      logic [1:0] exp;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            row_rd_en;
   logic [4:0]      row_addr;
   logic [MS*ES-1:0] row_data = '0;
   logic [MS*ES-1:0] p1 = '0;
   logic            axiov;
   logic [1:0]      axiod;
   logic            busy;
   logic            done;

   int mode = 0;
   int checks = 0;
   int errors = 0;
   int n_dib, first_v, last_v, n_rd, rd_bad, done_cnt, done_at, busy_bad, idle_nz, busy0;
   int rst_axiov, rst_busy, rst_addr;
   logic [1:0] dq[$];
   logic [7:0] cks_exp;
   vec_t vecs[20];

   always #5 clk = ~clk;

   matrix_sender #(
      .MAX_ELEMENT_SIZE (ES),
      .MAX_SIZE         (MS),
      .READ_LATENCY     (LAT)
   ) dut (
      .eth_refclk (clk),
      .rst        (rst),
      .start      (start),
      .row_rd_en  (row_rd_en),
      .row_addr   (row_addr),
      .row_data   (row_data),
      .axiov      (axiov),
      .axiod      (axiod),
      .busy       (busy),
      .done       (done)
   );

   function automatic logic [7:0] elem_val(input int m, input int r, input int c);
      logic [7:0] v;
      v = (m != 0) ? 8'hFF : 8'(r + c);
      return v;
   endfunction

   function automatic logic [MS*ES-1:0] build_row(input int m, input int r);
      logic [MS*ES-1:0] row;
      row = '0;
      for (int c = 0; c < MS; c++) row[(MS-1-c)*ES +: ES] = elem_val(m, r, c);
      return row;
   endfunction

   function automatic logic [1:0] exp_dibit(input int m, input int idx);
      logic [7:0] v;
      int e;
      if (idx < NDATA) begin
         e = idx / 4;
         v = elem_val(m, e / MS, e % MS);
      end else begin
         v = cks_exp;
      end
      return 2'((v >> (6 - 2 * (idx % 4))) & 8'h03);
   endfunction

   // Row source: request sampled on one edge, data presented two edges later.
   always @(posedge clk) begin
      if (row_rd_en) p1 <= build_row(mode, int'(row_addr));
      row_data <= p1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic watch(input int restart_at, input bit restart_on_done, input int rst_at);
      int abort_k;
      abort_k = -1;
      n_dib = 0; first_v = -1; last_v = -1; n_rd = 0; rd_bad = 0; done_cnt = 0;
      done_at = -1; busy_bad = 0; idle_nz = 0; busy0 = 0;
      rst_axiov = 1; rst_busy = 1; rst_addr = 1;
      dq.delete();
      for (int k = 0; k < 6000; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         rst   = 1'b0;
         if (k == 0) busy0 = int'(busy);
         if (axiov) begin
            if (first_v < 0) first_v = k;
            last_v = k;
            dq.push_back(axiod);
            n_dib++;
         end else if (axiod != 2'b00) begin
            idle_nz++;
         end
         if (row_rd_en) begin
            if (int'(row_addr) != n_rd) rd_bad++;
            n_rd++;
         end
         if (done) begin
            done_cnt++;
            done_at = k;
            if (busy) busy_bad++;
         end
         if (restart_at >= 0 && axiov && n_dib == restart_at) start = 1'b1;
         if (restart_on_done && done) start = 1'b1;
         if (rst_at >= 0 && abort_k < 0 && n_dib == rst_at) begin
            rst = 1'b1;
            #1;
            rst_axiov = int'(axiov);
            rst_busy  = int'(busy);
            rst_addr  = int'(row_addr);
            abort_k   = k;
         end
         if (done_at >= 0 && k >= done_at + 5) break;
         if (abort_k >= 0 && k >= abort_k + 10) break;
      end
   endtask

   task automatic check_full(input string tag);
      int mism;
      mism = 0;
      chk({tag, "_busy_at_accept"}, busy0, 1);
      chk({tag, "_first_valid_cycle"}, first_v, LAT + 2);
      chk({tag, "_dibit_count"}, n_dib, TOTAL);
      chk({tag, "_contiguous"}, last_v - first_v + 1, n_dib);
      chk({tag, "_read_count"}, n_rd, MS);
      chk({tag, "_read_order"}, rd_bad, 0);
      chk({tag, "_done_count"}, done_cnt, 1);
      chk({tag, "_done_timing"}, done_at, last_v + 1);
      chk({tag, "_busy_with_done"}, busy_bad, 0);
      chk({tag, "_idle_axiod"}, idle_nz, 0);
      for (int i = 0; i < dq.size(); i++) if (dq[i] != exp_dibit(mode, i)) mism++;
      chk({tag, "_stream"}, mism, 0);
      chk({tag, "_busy_after"}, int'(busy), 0);
   endtask

   initial begin
      vecs[0]  = '{"r0e0_d0", 0, 2'd0};      vecs[1]  = '{"r0e0_d1", 1, 2'd0};
      vecs[2]  = '{"r0e0_d2", 2, 2'd0};      vecs[3]  = '{"r0e0_d3", 3, 2'd0};
      vecs[4]  = '{"r0e5_d0", 20, 2'd0};     vecs[5]  = '{"r0e5_d1", 21, 2'd0};
      vecs[6]  = '{"r0e5_d2", 22, 2'd1};     vecs[7]  = '{"r0e5_d3", 23, 2'd1};
      vecs[8]  = '{"r1e0_d0", 128, 2'd0};    vecs[9]  = '{"r1e0_d1", 129, 2'd0};
      vecs[10] = '{"r1e0_d2", 130, 2'd0};    vecs[11] = '{"r1e0_d3", 131, 2'd1};
      vecs[12] = '{"r10e20_d0", 1360, 2'd0}; vecs[13] = '{"r10e20_d1", 1361, 2'd1};
      vecs[14] = '{"r10e20_d2", 1362, 2'd3}; vecs[15] = '{"r10e20_d3", 1363, 2'd2};
      vecs[16] = '{"r31e31_d0", 4092, 2'd0}; vecs[17] = '{"r31e31_d1", 4093, 2'd3};
      vecs[18] = '{"r31e31_d2", 4094, 2'd3}; vecs[19] = '{"r31e31_d3", 4095, 2'd2};

      cks_exp = '0;
      for (int r = 0; r < MS; r++)
         for (int c = 0; c < MS; c++) cks_exp = cks_exp ^ elem_val(0, r, c);

      rst = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_axiov", int'(axiov), 0);
      chk("reset_axiod", int'(axiod), 0);
      chk("reset_rd_en", int'(row_rd_en), 0);
      chk("reset_addr", int'(row_addr), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Plain transfer of r+c data.
      start = 1'b1;
      watch(-1, 1'b0, -1);
      check_full("base");
      for (int i = 0; i < 20; i++) begin
         chk(vecs[i].name, (vecs[i].idx < dq.size()) ? int'(dq[vecs[i].idx]) : -1, int'(vecs[i].exp));
      end
`ifdef MATRIX_SENDER_CHECKSUM_EN
      chk("cksum_value", (dq.size() == TOTAL) ?
          int'({dq[TOTAL-4], dq[TOTAL-3], dq[TOTAL-2], dq[TOTAL-1]}) : -1, int'(cks_exp));
`endif

      // start during the stream and on the done cycle must be ignored.
      start = 1'b1;
      watch(100, 1'b1, -1);
      check_full("restart");

      // Reset mid-stream, then a fresh transfer from row 0.
      start = 1'b1;
      watch(-1, 1'b0, 2000);
      chk("abort_axiov", rst_axiov, 0);
      chk("abort_busy", rst_busy, 0);
      chk("abort_addr", rst_addr, 0);
      chk("abort_dibits", n_dib, 2000);
      chk("abort_no_done", done_cnt, 0);
      start = 1'b1;
      watch(-1, 1'b0, -1);
      check_full("after_abort");

      // All-ones data.
      mode = 1;
      cks_exp = '0;
      start = 1'b1;
      watch(-1, 1'b0, -1);
      check_full("ones");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
